// File: rtl/car_dash_pkg.sv
// Shared types and constants for the car-dash obstacle field.
package car_dash_pkg;
  localparam int COLS = 16;
  localparam logic [COLS-1:0] BORDER_MASK = 16'b1000000110000001;
  localparam logic [1:0]      LIVES_INIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;
endpackage

// File: rtl/obstacle_row_shift.sv
// ROWS x COLS scrolling field: row 0 loads on shift, rows move toward ROWS-1.
// Also supports a synchronous clear and a single-bit clear on the bottom row.
module obstacle_row_shift
  import car_dash_pkg::*;
#(
  parameter int ROWS = 8
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_shift,
  input  logic [COLS-1:0]           i_row,
  input  logic                      i_bclr,
  input  logic [$clog2(COLS)-1:0]   i_bclr_col,
  output logic [ROWS-1:0][COLS-1:0] o_field
);
  logic [ROWS-1:0][COLS-1:0] r_field;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_field <= '0;
    else if (i_shift)
      r_field <= {r_field[ROWS-2:0], i_row};
    else if (i_bclr)
      r_field[ROWS-1][i_bclr_col] <= 1'b0;
  end

  assign o_field = r_field;
endmodule

// File: rtl/obstacle_field.sv
// Obstacle field consumer: scrolls generator rows, detects car hits, keeps score.
// Optional CAR_DASH_LIVES_EN gives three lives; a hit clears the struck cell.
module obstacle_field #(
  parameter int ROWS    = 8,
  parameter int COLS    = 16,
  parameter int SCORE_W = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tick,
  input  logic [0:15]          seq_in,
  input  logic [3:0]           player_col,
  output logic [ROWS*COLS-1:0] field_flat,
  output logic                 collision,
  output logic                 game_over,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           lives,
  output logic [1:0]           state
);
  import car_dash_pkg::*;

  state_t                    r_state, w_next;
  logic [SCORE_W-1:0]        r_score;
  logic [ROWS-1:0][COLS-1:0] w_field;
  logic [COLS-1:0]           w_row;
  logic                      w_hit, w_shift, w_restart, w_bclr;

  // seq_in is MSB-first (bit 0 = leftmost); store rows column-indexed.
  always_comb begin
    w_row = '0;
    for (int c = 0; c < COLS; c++) w_row[c] = seq_in[c];
  end

  assign w_hit     = (r_state == RUN) && w_field[ROWS-1][player_col];
  assign w_shift   = (r_state == RUN) && !w_hit && tick;
  assign w_restart = start && ((r_state == IDLE) || (r_state == OVER));

  obstacle_row_shift #(.ROWS(ROWS)) u_rows (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_restart),
    .i_shift    (w_shift),
    .i_row      (w_row),
    .i_bclr     (w_bclr),
    .i_bclr_col (player_col),
    .o_field    (w_field)
  );

`ifdef CAR_DASH_LIVES_EN
  logic [1:0] r_lives;
  always_ff @(posedge clk) begin
    if (rst || w_restart)    r_lives <= LIVES_INIT;
    else if (r_state == HIT) r_lives <= r_lives - 2'd1;
  end
  assign w_bclr = (r_state == HIT) && (r_lives > 2'd1);
  assign lives  = r_lives;
`else
  assign w_bclr = 1'b0;
  assign lives  = (r_state == OVER) ? 2'd0 : 2'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN:  if (w_hit) w_next = HIT;
`ifdef CAR_DASH_LIVES_EN
      HIT:  w_next = (r_lives > 2'd1) ? RUN : OVER;
`else
      HIT:  w_next = OVER;
`endif
      OVER: if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    collision = (r_state == HIT);
    game_over = (r_state == OVER);
    state     = r_state;
  end

  // Score saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || w_restart)
      r_score <= '0;
    else if (w_shift && (r_score != {SCORE_W{1'b1}}))
      r_score <= r_score + 1'b1;
  end

  assign score      = r_score;
  assign field_flat = w_field;
endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field (ROWS=8, SCORE_W=4 so saturation is reachable).
// Define CAR_DASH_LIVES_EN to exercise the three-lives build instead.
module tb_obstacle_field;
  localparam int ROWS = 8;
  localparam int COLS = 16;
  localparam int SW   = 4;

  logic                 clk = 1'b0;
  logic                 rst, start, tick;
  logic [0:15]          seq_in;
  logic [3:0]           player_col;
  logic [ROWS*COLS-1:0] field_flat;
  logic                 collision, game_over;
  logic [SW-1:0]        score;
  logic [1:0]           lives, state;

  int n_chk  = 0;
  int n_pass = 0;

  obstacle_field #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .seq_in(seq_in),
    .player_col(player_col), .field_flat(field_flat), .collision(collision),
    .game_over(game_over), .score(score), .lives(lives), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, start, tick;
    logic [15:0] seq;
    logic [3:0]  pc;
    logic [1:0]  st;
    int          sc;
    bit          col, go;
    logic [15:0] r0, r7;
  } vec_t;

  vec_t v[$];

  function automatic logic [15:0] row(input int r);
    return field_flat[r*COLS +: COLS];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, s, t, input logic [15:0] sq, input logic [3:0] pc,
                     input logic [1:0] st, input int sc, input bit col, go,
                     input logic [15:0] r0, r7);
    vec_t e;
    e.rst = r; e.start = s; e.tick = t; e.seq = sq; e.pc = pc;
    e.st = st; e.sc = sc; e.col = col; e.go = go; e.r0 = r0; e.r7 = r7;
    v.push_back(e);
  endtask

  task automatic drive(input bit r, s, t, input logic [15:0] sq, input logic [3:0] pc);
    rst = r; start = s; tick = t; seq_in = sq; player_col = pc;
  endtask

  initial begin
    drive(1, 0, 0, 16'h0, 4'd0);
`ifdef CAR_DASH_LIVES_EN
    step();
    chk("rst_lives", lives, 3);
    drive(0, 1, 0, 16'h0, 4'd0); step();
    chk("start_state", state, 1);
    for (int k = 0; k < 8; k++) begin drive(0, 0, 1, 16'h8181, 4'd0); step(); end
    drive(0, 0, 0, 16'h0, 4'd0); step();
    chk("hit1_state", state, 2); chk("hit1_col", collision, 1); chk("hit1_lives", lives, 3);
    step();
    chk("ret1_state", state, 1); chk("ret1_lives", lives, 2); chk("ret1_row7", row(7), 16'h8180);
    drive(0, 0, 0, 16'h0, 4'd15); step();
    chk("hit2_state", state, 2);
    step();
    chk("ret2_state", state, 1); chk("ret2_lives", lives, 1); chk("ret2_row7", row(7), 16'h0180);
    chk("ret2_score", score, 8);
    drive(0, 0, 0, 16'h0, 4'd7); step();
    chk("hit3_state", state, 2);
    step();
    chk("end_state", state, 3); chk("end_lives", lives, 0); chk("end_go", game_over, 1);
`else
    // Each vector: inputs held for one edge, outputs checked 1ns later.
    // Row expectations are column-indexed (bit c = column c), so MSB-first
    // 8981 appears as 8191 and 8581 as 81A1; 8181 is symmetric.
    add(1,0,0,16'h0000,3, 0,0,0,0, 16'h0000,16'h0000);
    add(0,0,1,16'hFFFF,3, 0,0,0,0, 16'h0000,16'h0000);
    add(0,1,0,16'h0000,3, 1,0,0,0, 16'h0000,16'h0000);
    for (int k = 1; k <= 8; k++)
      add(0,0,1,16'h8181,3, 1,k,0,0, 16'h8181,(k == 8) ? 16'h8181 : 16'h0000);
    add(0,0,0,16'hFFFF,3, 1,8,0,0, 16'h8181,16'h8181);
    add(1,1,1,16'h0000,3, 0,0,0,0, 16'h0000,16'h0000);
    add(0,1,0,16'h0000,4, 1,0,0,0, 16'h0000,16'h0000);
    add(0,0,1,16'h8981,4, 1,1,0,0, 16'h8191,16'h0000);
    for (int k = 2; k <= 8; k++)
      add(0,0,1,16'h8181,4, 1,k,0,0, 16'h8181,(k == 8) ? 16'h8191 : 16'h0000);
    add(0,0,1,16'h8181,4, 2,8,1,0, 16'h8181,16'h8191);
    add(0,0,1,16'h8181,4, 3,8,0,1, 16'h8181,16'h8191);
    add(0,0,1,16'hFFFF,4, 3,8,0,1, 16'h8181,16'h8191);
    add(0,0,1,16'hFFFF,4, 3,8,0,1, 16'h8181,16'h8191);
    add(0,1,0,16'h0000,4, 1,0,0,0, 16'h0000,16'h0000);
    add(0,0,1,16'h8581,4, 1,1,0,0, 16'h81A1,16'h0000);
    for (int k = 2; k <= 8; k++)
      add(0,0,1,16'h0000,4, 1,k,0,0, 16'h0000,(k == 8) ? 16'h81A1 : 16'h0000);
    add(0,0,0,16'h0000,4, 1,8,0,0, 16'h0000,16'h81A1);
    add(0,0,0,16'h0000,5, 2,8,1,0, 16'h0000,16'h81A1);
    add(0,1,0,16'h0000,5, 3,8,0,1, 16'h0000,16'h81A1);

    foreach (v[i]) begin
      drive(v[i].rst, v[i].start, v[i].tick, v[i].seq, v[i].pc);
      step();
      chk($sformatf("v%0d_state", i), state, v[i].st);
      chk($sformatf("v%0d_score", i), score, v[i].sc);
      chk($sformatf("v%0d_coll", i), collision, v[i].col);
      chk($sformatf("v%0d_gover", i), game_over, v[i].go);
      chk($sformatf("v%0d_lives", i), lives, (v[i].st == 2'd3) ? 0 : 1);
      chk($sformatf("v%0d_row0", i), row(0), v[i].r0);
      chk($sformatf("v%0d_row7", i), row(7), v[i].r7);
    end

    // Start ignored outside IDLE/OVER: the table left the DUT in OVER, so restart first.
    drive(0, 1, 0, 16'h0, 4'd5); step();
    chk("restart_state", state, 1);
    drive(0, 1, 0, 16'h0, 4'd5); step();
    chk("start_in_run_state", state, 1);
    // Score saturation at all-ones with a 4-bit counter.
    for (int k = 0; k < 17; k++) begin drive(0, 0, 1, 16'h0, 4'd5); step(); end
    chk("score_sat", score, 15);
    chk("sat_state", state, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
